reward_spawner: RTL

Generates the reward object that the reward display renders on the 20-pixel playfield grid. Drives `set_require`, `random_xpos`, `random_ypos` and `reward_type` into the display, detects the tank driving onto the reward cell, and reports the pickup with a one-cycle grant pulse. Also runs a timed effect window for the granted reward. Sits between the game-mode control and the reward display, in the VGA pixel-clock domain.

---
 rtl/reward_spawner_if.sv | 30 +++
 rtl/reward_spawner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reward_spawner_if.sv
// Signal bundle between game-mode control / tank logic (master) and the
// reward spawner (slave), which in turn feeds the reward display.
interface reward_spawner_if;
  logic       enable_game_classic;
  logic       enable_game_infinity;
  logic [4:0] tank_xpos;
  logic [4:0] tank_ypos;
  // set_require is a level (reward visible); reward_grant is a single-cycle
  // pulse with no back-pressure, consumed by whoever samples it that cycle.
  logic       set_require;
  logic [4:0] random_xpos;
  logic [4:0] random_ypos;
  logic [2:0] reward_type;
  logic       reward_grant;
  logic [2:0] effect_type;
  logic       effect_active;
  logic [1:0] dbg_state;

  modport master (
    output enable_game_classic, enable_game_infinity, tank_xpos, tank_ypos,
    input  set_require, random_xpos, random_ypos, reward_type,
    input  reward_grant, effect_type, effect_active, dbg_state
  );

  modport slave (
    input  enable_game_classic, enable_game_infinity, tank_xpos, tank_ypos,
    output set_require, random_xpos, random_ypos, reward_type,
    output reward_grant, effect_type, effect_active, dbg_state
  );
endinterface

// File: rtl/reward_spawner.sv
// Spawns a pseudo-random reward on the playfield grid, detects tank pickup
// and times the granted effect window.
module reward_spawner #(
  parameter int unsigned TICK_DIV     = 25_000_000,
  parameter int unsigned SPAWN_TICKS  = 5,
  parameter int unsigned LIFE_TICKS   = 10,
  parameter int unsigned EFFECT_TICKS = 8,
  parameter int unsigned X_MAX        = 27,
  parameter int unsigned Y_MAX        = 19,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic            clk,
  input logic            rst,
  reward_spawner_if.slave bus
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMAX = (SPAWN_TICKS > LIFE_TICKS) ? SPAWN_TICKS : LIFE_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned EW   = $clog2(EFFECT_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] SPAWN_LAST = TW'(SPAWN_TICKS - 1);
  localparam logic [TW-1:0] LIFE_LAST  = TW'(LIFE_TICKS - 1);
  localparam logic [EW-1:0] EFF_LOAD   = EW'(EFFECT_TICKS);
  localparam logic [4:0]    X_LIM      = 5'(X_MAX);
  localparam logic [4:0]    X_WRAP     = 5'(X_MAX + 1);
  localparam logic [4:0]    Y_LIM      = 5'(Y_MAX);
  localparam logic [4:0]    Y_WRAP     = 5'(Y_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHOW  = 2'd2,
    S_GRANT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          set_q, set_d;
  logic [4:0]    xpos_q, xpos_d;
  logic [4:0]    ypos_q, ypos_d;
  logic [2:0]    type_q, type_d;
  logic          grant_q, grant_d;
  logic [2:0]    eff_type_q, eff_type_d;
  logic [EW-1:0] eff_cnt_q, eff_cnt_d;
  logic [PW-1:0] eff_pre_q, eff_pre_d;
  logic          eff_active_q, eff_active_d;

  logic       game_en, tick, match, eff_load;
  logic [4:0] cand_x, cand_y;

  always_comb begin
    game_en = bus.enable_game_classic | bus.enable_game_infinity;
    tick    = (pre_q == PRE_LAST);
    match   = (bus.tank_xpos == xpos_q) && (bus.tank_ypos == ypos_q);
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Out-of-range raw coordinates fold back by one grid span.
    cand_x = lfsr_q[4:0];
    if (cand_x > X_LIM) cand_x = cand_x - X_WRAP;
    cand_y = lfsr_q[9:5];
    if (cand_y > Y_LIM) cand_y = cand_y - Y_WRAP;

    state_d    = state_q;
    pre_d      = tick ? '0 : pre_q + 1'b1;
    tcnt_d     = tcnt_q;
    set_d      = set_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    type_d     = type_q;
    grant_d    = 1'b0;
    eff_type_d = eff_type_q;
    eff_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        pre_d  = '0;
        tcnt_d = '0;
        set_d  = 1'b0;
        xpos_d = '0;
        ypos_d = '0;
        type_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick) begin
          if (tcnt_q == SPAWN_LAST) begin
            state_d = S_SHOW;
            pre_d   = '0;
            tcnt_d  = '0;
            set_d   = 1'b1;
            xpos_d  = cand_x;
            ypos_d  = cand_y;
            type_d  = {1'b0, lfsr_q[11:10]} + 3'd1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_SHOW: begin
        // Pickup takes priority over a simultaneous expiry tick.
        if (match) begin
          state_d    = S_GRANT;
          pre_d      = '0;
          tcnt_d     = '0;
          set_d      = 1'b0;
          grant_d    = 1'b1;
          eff_type_d = type_q;
          eff_load   = 1'b1;
        end else if (tick) begin
          if (tcnt_q == LIFE_LAST) begin
            state_d = S_WAIT;
            pre_d   = '0;
            tcnt_d  = '0;
            set_d   = 1'b0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_GRANT: begin
        state_d = S_WAIT;
        pre_d   = '0;
        tcnt_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // The effect window has its own phase so every grant lasts a full
    // EFFECT_TICKS * TICK_DIV clocks regardless of the spawn prescaler.
    eff_cnt_d = eff_cnt_q;
    eff_pre_d = '0;
    if (eff_cnt_q != '0) begin
      if (eff_pre_q == PRE_LAST) eff_cnt_d = eff_cnt_q - 1'b1;
      else                       eff_pre_d = eff_pre_q + 1'b1;
    end
    if (eff_load) begin
      eff_cnt_d = EFF_LOAD;
      eff_pre_d = '0;
    end

    if (!game_en) begin
      state_d    = S_IDLE;
      pre_d      = '0;
      tcnt_d     = '0;
      set_d      = 1'b0;
      xpos_d     = '0;
      ypos_d     = '0;
      type_d     = '0;
      grant_d    = 1'b0;
      eff_type_d = '0;
      eff_cnt_d  = '0;
      eff_pre_d  = '0;
    end

    eff_active_d = (eff_cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      pre_q        <= '0;
      tcnt_q       <= '0;
      set_q        <= 1'b0;
      xpos_q       <= '0;
      ypos_q       <= '0;
      type_q       <= '0;
      grant_q      <= 1'b0;
      eff_type_q   <= '0;
      eff_cnt_q    <= '0;
      eff_pre_q    <= '0;
      eff_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      pre_q        <= pre_d;
      tcnt_q       <= tcnt_d;
      set_q        <= set_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      type_q       <= type_d;
      grant_q      <= grant_d;
      eff_type_q   <= eff_type_d;
      eff_cnt_q    <= eff_cnt_d;
      eff_pre_q    <= eff_pre_d;
      eff_active_q <= eff_active_d;
    end
  end

  assign bus.set_require   = set_q;
  assign bus.random_xpos   = xpos_q;
  assign bus.random_ypos   = ypos_q;
  assign bus.reward_type   = type_q;
  assign bus.reward_grant  = grant_q;
  assign bus.effect_type   = eff_type_q;
  assign bus.effect_active = eff_active_q;
  assign bus.dbg_state     = state_q;

endmodule
